// File: rtl/cbuf_uart_tx.sv
// ---------------------------------------------------------------------------
// cbuf_uart_tx
// Reader side of the capture circular buffer. Whenever the buffer holds data
// (and fetching is enabled) it requests one byte with a get/byte_ready
// handshake, then sends that byte to the host PC as a UART 8N1 frame.
//
// Ports
//   rdclk       in   system clock, all logic on the rising edge
//   nreset      in   asynchronous active-low reset
//   en          in   1 = allowed to fetch new bytes (a frame in flight always completes)
//   byte_in     in   byte from the buffer, valid only while byte_ready=1
//   byte_ready  in   one-cycle pulse from the buffer: byte_in is valid
//   buf_empty   in   buffer empty flag
//   get         out  registered fetch request to the buffer
//   tx          out  UART serial line, idle high, driven from a register
//   busy        out  1 in every state except IDLE
//   sent_cnt    out  number of fully transmitted bytes, wraps to 0
// ---------------------------------------------------------------------------
module cbuf_uart_tx #(
    parameter int N      = 8,
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int CNT_W  = 16
) (
    input  logic             rdclk,
    input  logic             nreset,
    input  logic             en,
    input  logic [N-1:0]     byte_in,
    input  logic             byte_ready,
    input  logic             buf_empty,
    output logic             get,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (N > 1) ? $clog2(N) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]        state;
    logic [N-1:0]      shift_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic              baud_done;

    // Last cycle of the current bit period.
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign busy      = (state != IDLE);

    // Fetch handshake and frame serialiser. tx is updated on the same edge
    // that enters each bit, so every bit occupies exactly CLKS_PER_BIT cycles
    // and the line never glitches between bits.
    always_ff @(posedge rdclk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            get       <= 1'b0;
            tx        <= 1'b1;
            sent_cnt  <= '0;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && !buf_empty) begin
                        state <= REQ;
                        get   <= 1'b1;
                    end else begin
                        get <= 1'b0;
                    end
                end

                // The buffer may stall the fetch while it is being written,
                // so get stays high until byte_ready arrives; en is ignored.
                REQ: begin
                    if (byte_ready) begin
                        shift_reg <= byte_in;
                        get       <= 1'b0;
                        baud_cnt  <= '0;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                // shift_reg[1] is the next bit to appear after the shift.
                DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        sent_cnt <= sent_cnt + CNT_W'(1);
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    get   <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbuf_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_cbuf_uart_tx
// Scoreboard bench for cbuf_uart_tx with CLK_HZ=1000, BAUD=100 (10 clocks per
// bit). A buffer model answers get requests and pushes each delivered byte
// into the expected queue; an independent UART receiver model decodes frames
// from tx and compares them against that queue.
// ---------------------------------------------------------------------------
module tb_cbuf_uart_tx;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam int CPB   = 10;
    localparam int FRAME = (N + 2) * CPB;

    logic             rdclk;
    logic             nreset;
    logic             en;
    logic [N-1:0]     byte_in;
    logic             byte_ready;
    logic             buf_empty;
    logic             get;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] sent_cnt;

    cbuf_uart_tx #(
        .N(N),
        .CLK_HZ(1000),
        .BAUD(100),
        .CNT_W(CNT_W)
    ) dut (
        .rdclk(rdclk),
        .nreset(nreset),
        .en(en),
        .byte_in(byte_in),
        .byte_ready(byte_ready),
        .buf_empty(buf_empty),
        .get(get),
        .tx(tx),
        .busy(busy),
        .sent_cnt(sent_cnt)
    );

    initial rdclk = 1'b0;
    always #5 rdclk = ~rdclk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] buf_q[$];
    logic [7:0] exp_q[$];
    int         ready_delay = 1;
    int         spur_req    = 0;
    int         spur_done   = 0;
    int         frames_seen = 0;
    int         exp_sent    = 0;

    int   get_cycles       = 0;
    int   get_pulses       = 0;
    int   tx_low_while_get = 0;
    logic get_prev         = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Loads a byte into the buffer model.
    task automatic applyStimulus(input logic [7:0] b);
        buf_q.push_back(b);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge rdclk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c = 0;
        while (frames_seen < target && c < budget) begin
            @(negedge rdclk);
            c++;
        end
        checkOutput("frame_count", frames_seen, target);
    endtask

    // Handshake observers for get timing and the idle-line requirement.
    always @(negedge rdclk) begin
        get_prev <= get;
        if (get) get_cycles <= get_cycles + 1;
        if (get && !get_prev) get_pulses <= get_pulses + 1;
        if (get && !tx) tx_low_while_get <= tx_low_while_get + 1;
    end

    // Buffer model: answers get after ready_delay cycles with a one-cycle
    // byte_ready pulse; also injects byte_ready pulses while nothing is asked.
    initial begin
        byte_ready = 1'b0;
        byte_in    = '0;
        buf_empty  = 1'b1;
        forever begin
            @(negedge rdclk);
            buf_empty = (buf_q.size() == 0);
            if (get === 1'b1 && buf_q.size() > 0) begin
                repeat (ready_delay) @(posedge rdclk);
                #1;
                byte_in    = buf_q.pop_front();
                byte_ready = 1'b1;
                exp_q.push_back(byte_in);
                buf_empty  = (buf_q.size() == 0);
                @(posedge rdclk);
                #1;
                byte_ready = 1'b0;
                byte_in    = '0;
            end else if (spur_req != spur_done) begin
                @(posedge rdclk);
                #1;
                byte_in    = 8'h77;
                byte_ready = 1'b1;
                @(posedge rdclk);
                #1;
                byte_ready = 1'b0;
                byte_in    = '0;
                spur_done++;
            end
        end
    end

    // UART receiver model: on a falling tx edge, sample one full frame on
    // negedges, require each bit to hold for exactly CPB samples, then compare
    // the decoded byte with the scoreboard. Frames cut by reset are dropped.
    initial begin
        logic       prev;
        logic       ok;
        logic       aborted;
        logic [7:0] data;
        logic [7:0] want;
        int         bitpos;
        prev = 1'b1;
        forever begin
            @(negedge rdclk);
            if (nreset && prev && !tx) begin
                ok      = 1'b1;
                aborted = 1'b0;
                data    = '0;
                for (int s = 0; s < FRAME; s++) begin
                    if (s > 0) @(negedge rdclk);
                    if (!nreset) begin
                        aborted = 1'b1;
                        break;
                    end
                    bitpos = s / CPB;
                    if (bitpos == 0) begin
                        if (tx !== 1'b0) ok = 1'b0;
                    end else if (bitpos == N + 1) begin
                        if (tx !== 1'b1) ok = 1'b0;
                    end else if (s % CPB == 0) begin
                        data[bitpos-1] = tx;
                    end else if (tx !== data[bitpos-1]) begin
                        ok = 1'b0;
                    end
                    if (busy !== 1'b1) ok = 1'b0;
                end
                if (!aborted) begin
                    frames_seen++;
                    checkOutput("frame_shape", {31'd0, ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check_cnt++;
                        $display("[TB] FAIL frame_unexpected: got 0x%0h, expected no frame", data);
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("frame_byte", {24'd0, data}, {24'd0, want});
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin
        int base_cyc;
        int base_pulse;
        int base_low;
        int c;

        // 1: reset state, then idle with an empty buffer
        nreset = 1'b0;
        en     = 1'b0;
        wait_cycles(3);
        checkOutput("rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("rst_get", {31'd0, get}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_sent_cnt", {16'd0, sent_cnt}, 32'd0);
        @(posedge rdclk);
        #1 nreset = 1'b1;
        en = 1'b1;
        wait_cycles(5);
        checkOutput("idle_empty_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_empty_get", {31'd0, get}, 32'd0);

        // 2: single byte 0xA5, buffer answers one cycle after get
        base_cyc   = get_cycles;
        base_pulse = get_pulses;
        applyStimulus(8'hA5);
        exp_sent++;
        wait_frames(1, 300);
        wait_cycles(3);
        checkOutput("t2_sent_cnt", {16'd0, sent_cnt}, exp_sent);
        checkOutput("t2_get_cycles", get_cycles - base_cyc, 2);
        checkOutput("t2_get_pulses", get_pulses - base_pulse, 1);

        // 3: byte_ready withheld for 7 cycles
        ready_delay = 7;
        base_cyc    = get_cycles;
        base_low    = tx_low_while_get;
        applyStimulus(8'h5A);
        exp_sent++;
        wait_frames(2, 300);
        wait_cycles(3);
        checkOutput("t3_get_cycles", get_cycles - base_cyc, 8);
        checkOutput("t3_tx_idle_during_get", tx_low_while_get - base_low, 0);
        checkOutput("t3_sent_cnt", {16'd0, sent_cnt}, exp_sent);

        // 4: burst of three bytes with the buffer non-empty throughout
        ready_delay = 1;
        base_pulse  = get_pulses;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        exp_sent += 3;
        wait_frames(5, 800);
        wait_cycles(5);
        checkOutput("t4_get_pulses", get_pulses - base_pulse, 3);
        checkOutput("t4_sent_cnt", {16'd0, sent_cnt}, exp_sent);
        checkOutput("t4_buf_drained", buf_q.size(), 0);

        // 5: en dropped mid-DATA; frame completes, no further fetch until en=1
        base_pulse = get_pulses;
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        c = 0;
        while (get_pulses == base_pulse && c < 100) begin
            @(negedge rdclk);
            c++;
        end
        wait_cycles(40);
        en = 1'b0;
        exp_sent++;
        wait_frames(6, 300);
        wait_cycles(50);
        checkOutput("t5_get_pulses_en0", get_pulses - base_pulse, 1);
        checkOutput("t5_busy_en0", {31'd0, busy}, 32'd0);
        checkOutput("t5_buf_left", buf_q.size(), 1);
        checkOutput("t5_sent_cnt_en0", {16'd0, sent_cnt}, exp_sent);
        en = 1'b1;
        exp_sent++;
        wait_frames(7, 300);
        wait_cycles(3);
        checkOutput("t5_get_pulses_en1", get_pulses - base_pulse, 2);
        checkOutput("t5_sent_cnt_en1", {16'd0, sent_cnt}, exp_sent);

        // 6: reset at cycle 45 of a frame, then a stray byte_ready in IDLE
        applyStimulus(8'h99);
        c = 0;
        while (!(busy === 1'b1 && tx === 1'b0) && c < 100) begin
            @(negedge rdclk);
            c++;
        end
        wait_cycles(44);
        #2 nreset = 1'b0;
        #1;
        checkOutput("t6_rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_get", {31'd0, get}, 32'd0);
        checkOutput("t6_rst_sent_cnt", {16'd0, sent_cnt}, 32'd0);
        repeat (2) @(posedge rdclk);
        #1 nreset = 1'b1;
        exp_q.delete();
        exp_sent = 0;
        wait_cycles(3);
        spur_req++;
        wait_cycles(10);
        checkOutput("t6_spur_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_spur_get", {31'd0, get}, 32'd0);
        checkOutput("t6_spur_tx", {31'd0, tx}, 32'd1);
        checkOutput("t6_spur_frames", frames_seen, 7);
        checkOutput("t6_spur_sent_cnt", {16'd0, sent_cnt}, 32'd0);
        applyStimulus(8'h3E);
        exp_sent++;
        wait_frames(8, 300);
        wait_cycles(3);
        checkOutput("t6_sent_cnt_after", {16'd0, sent_cnt}, exp_sent);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
